// File: rtl/splat_prefetch.sv
// Streams a tile's inline splat list out of DDR3 in multi-splat bursts and hands
// it to splat_reader as a first-word-fall-through valid/ready qword stream.
module splat_prefetch #(
    parameter int unsigned FIFO_DEPTH      = 64,
    parameter int unsigned MAX_BURST       = 32,
    parameter int unsigned WORDS_PER_SPLAT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [28:0] base_addr,
    input  logic [15:0] splat_count,
    output logic [28:0] rd_addr,
    output logic [7:0]  rd_burstcnt,
    output logic        rd_req,
    input  logic        rd_ack,
    input  logic [63:0] rd_data,
    input  logic        rd_data_valid,
    output logic [63:0] word_data,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        busy,
    output logic        done
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_SPACE, S_REQ, S_DATA, S_DRAIN, S_FLUSH
    } state_e;

    state_e        state_q, state_d;
    logic [17:0]   words_left_q, words_left_d;
    logic [28:0]   next_addr_q, next_addr_d;
    logic [7:0]    burst_left_q, burst_left_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          rd_req_q, rd_req_d;
    logic [28:0]   rd_addr_q, rd_addr_d;
    logic [7:0]    rd_burstcnt_q, rd_burstcnt_d;
    logic          done_q, done_d;
    logic          abort_pend_q, abort_pend_d;

    logic [63:0]   fifo_mem [FIFO_DEPTH];
    logic          push, pop, fifo_clr;
    logic [7:0]    blen;
    logic [CW-1:0] fifo_space;

    assign word_valid  = (fifo_cnt_q != '0);
    assign word_data   = fifo_mem[rd_ptr_q];
    assign pop         = word_valid & word_ready;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign rd_req      = rd_req_q;
    assign rd_addr     = rd_addr_q;
    assign rd_burstcnt = rd_burstcnt_q;

    assign blen = (words_left_q < 18'(MAX_BURST)) ? words_left_q[7:0] : 8'(MAX_BURST);
    assign fifo_space = CW'(FIFO_DEPTH) - fifo_cnt_q;

    always_comb begin
        state_d       = state_q;
        words_left_d  = words_left_q;
        next_addr_d   = next_addr_q;
        burst_left_d  = burst_left_q;
        rd_req_d      = rd_req_q;
        rd_addr_d     = rd_addr_q;
        rd_burstcnt_d = rd_burstcnt_q;
        abort_pend_d  = abort_pend_q;
        done_d        = 1'b0;
        push          = 1'b0;
        fifo_clr      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    words_left_d = 18'(splat_count) * 18'(WORDS_PER_SPLAT);
                    next_addr_d  = base_addr;
                    state_d      = (splat_count == 16'd0) ? S_DRAIN : S_WAIT_SPACE;
                end
            end
            S_WAIT_SPACE: begin
                if (abort) begin
                    fifo_clr = 1'b1;
                    state_d  = S_FLUSH;
                end else if (16'(fifo_space) >= 16'(blen)) begin
                    rd_req_d      = 1'b1;
                    rd_addr_d     = next_addr_q;
                    rd_burstcnt_d = blen;
                    state_d       = S_REQ;
                end
            end
            S_REQ: begin
                // A request cannot be withdrawn; remember the abort and flush after the ack.
                if (abort) begin
                    fifo_clr     = 1'b1;
                    abort_pend_d = 1'b1;
                end
                if (rd_ack) begin
                    rd_req_d     = 1'b0;
                    burst_left_d = rd_burstcnt_q;
                    next_addr_d  = next_addr_q + 29'(rd_burstcnt_q);
                    words_left_d = words_left_q - 18'(rd_burstcnt_q);
                    abort_pend_d = 1'b0;
                    state_d      = (abort || abort_pend_q) ? S_FLUSH : S_DATA;
                end
            end
            S_DATA: begin
                if (rd_data_valid) burst_left_d = burst_left_q - 8'd1;
                if (abort) begin
                    fifo_clr = 1'b1;
                    state_d  = S_FLUSH;
                end else if (rd_data_valid) begin
                    push = 1'b1;
                    if (burst_left_q == 8'd1) begin
                        state_d = (words_left_q != '0) ? S_WAIT_SPACE : S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    fifo_clr = 1'b1;
                    state_d  = S_FLUSH;
                end else if (fifo_cnt_q == '0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (rd_data_valid && burst_left_q != 8'd0) burst_left_d = burst_left_q - 8'd1;
                if (burst_left_q == 8'd0 || (rd_data_valid && burst_left_q == 8'd1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fifo_clr) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fifo_cnt_d = '0;
        end else begin
            wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
            rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
            fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            words_left_q  <= '0;
            next_addr_q   <= '0;
            burst_left_q  <= '0;
            fifo_cnt_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            rd_req_q      <= 1'b0;
            rd_addr_q     <= '0;
            rd_burstcnt_q <= '0;
            done_q        <= 1'b0;
            abort_pend_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            words_left_q  <= words_left_d;
            next_addr_q   <= next_addr_d;
            burst_left_q  <= burst_left_d;
            fifo_cnt_q    <= fifo_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            rd_req_q      <= rd_req_d;
            rd_addr_q     <= rd_addr_d;
            rd_burstcnt_q <= rd_burstcnt_d;
            done_q        <= done_d;
            abort_pend_q  <= abort_pend_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= rd_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && fifo_cnt_q == CW'(FIFO_DEPTH)));
            assert (!(rd_data_valid && state_q != S_DATA && state_q != S_FLUSH));
        end
    end

endmodule

// File: tb/tb_splat_prefetch.sv
// Directed bench for splat_prefetch: a scripted DDR read channel feeds known
// address-tagged qwords and a negedge monitor collects what the consumer pops.
module tb_splat_prefetch;

    logic        clk = 1'b0;
    logic        reset, start, abort, rd_ack, rd_data_valid, word_ready;
    logic [28:0] base_addr, rd_addr;
    logic [15:0] splat_count;
    logic [7:0]  rd_burstcnt;
    logic        rd_req, word_valid, busy, done;
    logic [63:0] rd_data, word_data;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    logic [63:0] got[$];

    splat_prefetch dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .base_addr(base_addr), .splat_count(splat_count),
        .rd_addr(rd_addr), .rd_burstcnt(rd_burstcnt), .rd_req(rd_req), .rd_ack(rd_ack),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (word_valid && word_ready) got.push_back(word_data);
            if (done) done_cnt++;
        end
    end

    function automatic logic [63:0] pat(input logic [28:0] a);
        return {3'b000, a, 3'b101, ~a};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic req_phase(input logic [28:0] a, input logic [7:0] len, input int delay);
        int t = 0;
        bit stable = 1'b1;
        while (!rd_req && t < 300) begin
            step();
            t++;
        end
        chk("req_seen", rd_req, 1);
        chk("req_addr", rd_addr, a);
        chk("req_len", rd_burstcnt, len);
        for (int i = 0; i < delay; i++) begin
            step();
            if (!(rd_req === 1'b1 && rd_addr === a && rd_burstcnt === len)) stable = 1'b0;
        end
        chk("req_stable", stable, 1);
        rd_ack = 1'b1;
        step();
        rd_ack = 1'b0;
        chk("req_drop", rd_req, 0);
    endtask

    task automatic data_phase(input logic [28:0] a, input int n);
        for (int i = 0; i < n; i++) begin
            rd_data_valid = 1'b1;
            rd_data = pat(a + 29'(i));
            step();
        end
        rd_data_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 400) begin
            step();
            t++;
        end
        chk("idle_timeout", busy, 0);
        step();
        step();
    endtask

    task automatic check_stream(input string tag, input logic [28:0] a, input int n);
        int errs = 0;
        chk({tag, "_count"}, 64'(got.size()), 64'(n));
        for (int i = 0; i < got.size() && i < n; i++) begin
            if (got[i] !== pat(a + 29'(i))) errs++;
        end
        chk({tag, "_order"}, 64'(errs), 0);
    endtask

    task automatic kick(input logic [28:0] a, input logic [15:0] cnt);
        got.delete();
        done_cnt = 0;
        base_addr = a;
        splat_count = cnt;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        bit quiet;
        reset = 1'b1; start = 1'b0; abort = 1'b0; rd_ack = 1'b0; rd_data_valid = 1'b0;
        word_ready = 1'b0; base_addr = '0; splat_count = '0; rd_data = '0;
        repeat (3) step();
        chk("rst_req", rd_req, 0);
        chk("rst_addr", rd_addr, 0);
        chk("rst_len", rd_burstcnt, 0);
        chk("rst_wvalid", word_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;
        step();

        // Zero-count: done two cycles after the start pulse, no read.
        kick(29'h0, 16'd0);
        chk("zero_busy", busy, 1);
        chk("zero_done_early", done, 0);
        step();
        chk("zero_done", done, 1);
        chk("zero_busy_clr", busy, 0);
        chk("zero_noreq", rd_req, 0);
        step();
        chk("zero_done_pulse", done, 0);

        // Single splat.
        word_ready = 1'b1;
        kick(29'h100, 16'd1);
        req_phase(29'h100, 8'd4, 0);
        data_phase(29'h100, 4);
        wait_idle();
        check_stream("single", 29'h100, 4);
        chk("single_done", 64'(done_cnt), 1);

        // Multi-burst: 80 qwords as 32+32+16.
        kick(29'h200, 16'd20);
        req_phase(29'h200, 8'd32, 0);
        data_phase(29'h200, 32);
        req_phase(29'h220, 8'd32, 0);
        data_phase(29'h220, 32);
        req_phase(29'h240, 8'd16, 0);
        data_phase(29'h240, 16);
        wait_idle();
        check_stream("multi", 29'h200, 80);
        chk("multi_done", 64'(done_cnt), 1);

        // Backpressure: two bursts fill the FIFO, third waits for space.
        word_ready = 1'b0;
        kick(29'h300, 16'd20);
        req_phase(29'h300, 8'd32, 0);
        data_phase(29'h300, 32);
        req_phase(29'h320, 8'd32, 0);
        data_phase(29'h320, 32);
        quiet = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (rd_req !== 1'b0) quiet = 1'b0;
        end
        chk("bp_no_third_req", quiet, 1);
        chk("bp_wvalid", word_valid, 1);
        chk("bp_nothing_popped", 64'(got.size()), 0);
        word_ready = 1'b1;
        req_phase(29'h340, 8'd16, 0);
        data_phase(29'h340, 16);
        wait_idle();
        check_stream("bp", 29'h300, 80);
        chk("bp_done", 64'(done_cnt), 1);

        // Abort after 10 of 32 qwords.
        kick(29'h400, 16'd8);
        req_phase(29'h400, 8'd32, 0);
        data_phase(29'h400, 10);
        abort = 1'b1;
        step();
        abort = 1'b0;
        got.delete();
        chk("abort_wvalid", word_valid, 0);
        chk("abort_busy", busy, 1);
        data_phase(29'h40A, 21);
        chk("abort_busy_last", busy, 1);
        data_phase(29'h41F, 1);
        chk("abort_idle", busy, 0);
        step();
        step();
        chk("abort_no_done", 64'(done_cnt), 0);
        chk("abort_no_words", 64'(got.size()), 0);
        kick(29'h500, 16'd1);
        req_phase(29'h500, 8'd4, 0);
        data_phase(29'h500, 4);
        wait_idle();
        check_stream("post_abort", 29'h500, 4);
        chk("post_abort_done", 64'(done_cnt), 1);

        // Delayed ack and address wrap.
        kick(29'h1FFF_FFFE, 16'd1);
        req_phase(29'h1FFF_FFFE, 8'd4, 7);
        data_phase(29'h1FFF_FFFE, 4);
        wait_idle();
        check_stream("wrap", 29'h1FFF_FFFE, 4);
        chk("wrap_done", 64'(done_cnt), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
